// File: rtl/prefetcher_pkg.sv
// Shared constants and helpers for the instruction prefetcher and its byte queue.
package prefetcher_pkg;

  localparam int TX_CMD_BITS = 4;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16 = 4'h2;

  localparam int ADDR_BITS = 16;
  localparam int CNT_BITS  = 3;

  function automatic logic [ADDR_BITS-1:0] addr_plus2(input logic [ADDR_BITS-1:0] a);
    return a + ADDR_BITS'(2);
  endfunction

endpackage

// File: rtl/prefetch_queue.sv
// Byte FIFO for fetched instruction bytes: 2-byte push, 0..2-byte pop, pop applied before push.
module prefetch_queue
  import prefetcher_pkg::*;
#(
  parameter int REG_BITS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [2*REG_BITS-1:0] push_data,
  input  logic [1:0]            pop,
  output logic [2*REG_BITS-1:0] head,
  output logic [CNT_BITS-1:0]   count
);

  logic [REG_BITS-1:0] mem_q [DEPTH];
  logic [REG_BITS-1:0] mem_d [DEPTH];
  logic [REG_BITS-1:0] ext   [DEPTH+2];
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] kept;

  // Two zero pad slots let the shift-down read past the end without range checks.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = mem_q[i];
    ext[DEPTH]   = '0;
    ext[DEPTH+1] = '0;
  end

  always_comb begin
    kept    = count_q - CNT_BITS'(pop);
    count_d = flush ? '0 : kept + (push ? CNT_BITS'(2) : '0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (CNT_BITS'(i) < kept) begin
        case (pop)
          2'd0:    mem_d[i] = ext[i];
          2'd1:    mem_d[i] = ext[i+1];
          default: mem_d[i] = ext[i+2];
        endcase
      end else if (push && CNT_BITS'(i) == kept) begin
        mem_d[i] = push_data[REG_BITS-1:0];
      end else if (push && CNT_BITS'(i) == kept + CNT_BITS'(1)) begin
        mem_d[i] = push_data[2*REG_BITS-1:REG_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign head  = {mem_q[1], mem_q[0]};
  assign count = count_q;

endmodule

// File: rtl/prefetcher.sv
// Instruction prefetch unit: owns the PC, fills a small byte queue over the shared TX/RX
// channel, serves imm16 loads and serialises the PC to/from the scheduler.
module prefetcher
  import prefetcher_pkg::*;
#(
  parameter int REG_BITS    = 8,
  parameter int NSHIFT      = 2,
  parameter int QUEUE_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [2*REG_BITS-1:0]  q_data,
  output logic [CNT_BITS-1:0]    q_count,
  input  logic [1:0]             consume,
  input  logic                   load_imm16,
  output logic                   imm16_loaded,
  input  logic                   next_imm_data,
  output logic [NSHIFT-1:0]      imm_data,
  input  logic                   block_prefetch,
  input  logic                   write_pc_now,
  input  logic                   ext_pc_next,
  output logic                   prefetch_idle,
  output logic [NSHIFT-1:0]      pc_data,
  input  logic [NSHIFT-1:0]      pc_data_new,
  input  logic                   reserve_tx,
  output logic                   tx_command_valid,
  output logic [TX_CMD_BITS-1:0] tx_command,
  input  logic                   tx_command_started,
  input  logic                   tx_data_next,
  output logic [NSHIFT-1:0]      tx_data,
  input  logic                   rx_data_valid,
  input  logic                   rx_done,
  input  logic [NSHIFT-1:0]      rx_pins
);

  localparam int WORD   = ADDR_BITS;
  localparam int PHASES = WORD / NSHIFT;
  localparam int PH_W   = $clog2(PHASES);

  logic [WORD-1:0] pc_q, pc_d, fetch_q, fetch_d;
  logic [WORD-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, imm_q, imm_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            pc_write_q, pc_write_d, outstanding_q, outstanding_d;
  logic            jump_q, jump_d, cmd_pending_q, cmd_pending_d, imm_loaded_q, imm_loaded_d;

  logic            imm_take, rx_accept, pc_wrap, cmd_accept, room_ok, req_ok;
  logic [1:0]      pop;
  logic [3:0]      committed;
  logic [WORD-1:0] rx_word;
  logic [NSHIFT-1:0] pc_top;

  prefetch_queue #(
    .REG_BITS (REG_BITS),
    .DEPTH    (QUEUE_BYTES)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (write_pc_now),
    .push      (rx_accept),
    .push_data (rx_word),
    .pop       (pop),
    .head      (q_data),
    .count     (q_count)
  );

  assign imm_take   = load_imm16 && !imm_loaded_q && (q_count >= CNT_BITS'(2));
  assign pop        = imm_take ? 2'd2 : consume;
  assign rx_word    = rx_data_valid ? {rx_pins, rx_shift_q[WORD-1:NSHIFT]} : rx_shift_q;
  assign rx_accept  = rx_done && outstanding_q;
  assign cmd_accept = tx_command_started && cmd_pending_q;
  assign pc_top     = (pc_write_q || write_pc_now) ? pc_data_new : pc_q[NSHIFT-1:0];
  assign pc_wrap    = ext_pc_next && (phase_q == PH_W'(PHASES-1));
  // Bytes already in the queue plus those an in-flight read will still deliver.
  assign committed  = {1'b0, q_count} + (outstanding_q ? 4'd2 : 4'd0);
  assign room_ok    = (committed + 4'd2) <= 4'(QUEUE_BYTES);
  assign req_ok     = room_ok && !outstanding_q && !pc_write_q && !load_imm16;

  always_comb begin
    cmd_pending_d = cmd_pending_q;
    if (cmd_accept)                                        cmd_pending_d = 1'b0;
    else if (block_prefetch || reserve_tx || write_pc_now) cmd_pending_d = 1'b0;
    else if (!cmd_pending_q && req_ok)                     cmd_pending_d = 1'b1;

    outstanding_d = outstanding_q;
    if (write_pc_now || cmd_accept) outstanding_d = 1'b1;
    else if (rx_accept)             outstanding_d = 1'b0;

    jump_d = jump_q;
    if (write_pc_now)   jump_d = 1'b1;
    else if (rx_accept) jump_d = 1'b0;

    tx_shift_d = tx_shift_q;
    if (cmd_accept)        tx_shift_d = fetch_q;
    else if (tx_data_next) tx_shift_d = tx_shift_q >> NSHIFT;

    rx_shift_d = rx_word;

    imm_d = imm_q;
    if (imm_take)           imm_d = q_data;
    else if (next_imm_data) imm_d = imm_q >> NSHIFT;
    imm_loaded_d = imm_take;

    pc_d = pc_q;
    if (ext_pc_next)   pc_d = {pc_top, pc_q[WORD-1:NSHIFT]};
    else if (imm_take) pc_d = addr_plus2(pc_q);
    else               pc_d = pc_q + WORD'(consume);
    phase_d = ext_pc_next ? phase_q + PH_W'(1) : phase_q;

    pc_write_d = pc_write_q;
    if (write_pc_now) pc_write_d = 1'b1;
    else if (pc_wrap) pc_write_d = 1'b0;

    // A jump reply covers the new PC itself; the next fetch address comes from the write.
    fetch_d = fetch_q;
    if (pc_wrap && pc_write_q)      fetch_d = addr_plus2(pc_d);
    else if (rx_accept && !jump_q)  fetch_d = addr_plus2(fetch_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      fetch_q       <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      imm_q         <= '0;
      phase_q       <= '0;
      pc_write_q    <= 1'b0;
      outstanding_q <= 1'b0;
      jump_q        <= 1'b0;
      cmd_pending_q <= 1'b0;
      imm_loaded_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_q       <= fetch_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      imm_q         <= imm_d;
      phase_q       <= phase_d;
      pc_write_q    <= pc_write_d;
      outstanding_q <= outstanding_d;
      jump_q        <= jump_d;
      cmd_pending_q <= cmd_pending_d;
      imm_loaded_q  <= imm_loaded_d;
    end
  end

  assign tx_command_valid = cmd_pending_q;
  assign tx_command       = TX_HEADER_READ_16;
  assign tx_data          = tx_shift_q[NSHIFT-1:0];
  assign imm_data         = imm_q[NSHIFT-1:0];
  assign imm16_loaded     = imm_loaded_q;
  assign pc_data          = pc_q[NSHIFT-1:0];
  assign prefetch_idle    = !cmd_pending_q && !outstanding_q;

  a_consume_legal: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, consume} <= q_count));

endmodule

// File: tb/tb_prefetcher.sv
// Self-checking bench for prefetcher: scenario tasks against a byte-queue / PC reference model.
module tb_prefetcher;
  import prefetcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] q_data;
  logic [2:0]  q_count;
  logic [1:0]  consume;
  logic        load_imm16, imm16_loaded, next_imm_data;
  logic [1:0]  imm_data;
  logic        block_prefetch, write_pc_now, ext_pc_next, prefetch_idle;
  logic [1:0]  pc_data, pc_data_new;
  logic        reserve_tx, tx_command_valid, tx_command_started, tx_data_next;
  logic [TX_CMD_BITS-1:0] tx_command;
  logic [1:0]  tx_data;
  logic        rx_data_valid, rx_done;
  logic [1:0]  rx_pins;

  int tests_run = 0;
  int failed    = 0;

  // Reference model: queued bytes, architectural PC, next fetch address.
  logic [7:0]  mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_fetch;

  prefetcher #(.REG_BITS(8), .NSHIFT(2), .QUEUE_BYTES(4)) dut (
    .clk(clk), .reset(reset), .q_data(q_data), .q_count(q_count), .consume(consume),
    .load_imm16(load_imm16), .imm16_loaded(imm16_loaded), .next_imm_data(next_imm_data),
    .imm_data(imm_data), .block_prefetch(block_prefetch), .write_pc_now(write_pc_now),
    .ext_pc_next(ext_pc_next), .prefetch_idle(prefetch_idle), .pc_data(pc_data),
    .pc_data_new(pc_data_new), .reserve_tx(reserve_tx), .tx_command_valid(tx_command_valid),
    .tx_command(tx_command), .tx_command_started(tx_command_started),
    .tx_data_next(tx_data_next), .tx_data(tx_data), .rx_data_valid(rx_data_valid),
    .rx_done(rx_done), .rx_pins(rx_pins)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    consume = 2'd0; load_imm16 = 1'b0; next_imm_data = 1'b0; block_prefetch = 1'b0;
    write_pc_now = 1'b0; ext_pc_next = 1'b0; pc_data_new = 2'd0; reserve_tx = 1'b0;
    tx_command_started = 1'b0; tx_data_next = 1'b0; rx_data_valid = 1'b0; rx_done = 1'b0;
    rx_pins = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    m_pc = 16'h0000;
    m_fetch = 16'h0000;
  endtask

  task automatic pc_readout(output logic [15:0] v);
    v = '0;
    for (int k = 0; k < 8; k++) begin
      ext_pc_next = 1'b1;
      v[2*k +: 2] = pc_data;
      tick();
    end
    ext_pc_next = 1'b0;
  endtask

  // Full read transaction as memory: accept the command, check the address, send the reply.
  task automatic serve_read(input logic [15:0] exp_addr, input logic [7:0] b0, input logic [7:0] b1);
    int waited;
    logic [15:0] addr;
    logic [15:0] word;
    waited = 0;
    while (tx_command_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    tests_run++;
    if (tx_command_valid !== 1'b1) begin
      failed++;
      $display("FAIL cmd_wait: tx_command_valid=%b after %0d cycles, required 1", tx_command_valid, waited);
      return;
    end
    tests_run++;
    if (tx_command !== TX_HEADER_READ_16) begin
      failed++;
      $display("FAIL cmd_code: got %h, required %h", tx_command, TX_HEADER_READ_16);
    end
    tx_command_started = 1'b1;
    tick();
    tx_command_started = 1'b0;
    tests_run++;
    if (tx_command_valid !== 1'b0 || prefetch_idle !== 1'b0) begin
      failed++;
      $display("FAIL cmd_accept: valid=%b idle=%b, required valid=0 idle=0", tx_command_valid, prefetch_idle);
    end
    addr = '0;
    for (int k = 0; k < 8; k++) begin
      tx_data_next = 1'b1;
      addr[2*k +: 2] = tx_data;
      tick();
    end
    tx_data_next = 1'b0;
    tests_run++;
    if (addr !== exp_addr) begin
      failed++;
      $display("FAIL read_addr: got %04h, required %04h", addr, exp_addr);
    end
    word = {b1, b0};
    for (int k = 0; k < 8; k++) begin
      rx_data_valid = 1'b1;
      rx_pins = word[2*k +: 2];
      rx_done = (k == 7);
      tick();
    end
    rx_data_valid = 1'b0;
    rx_done = 1'b0;
    mq.push_back(b0);
    mq.push_back(b1);
    m_fetch = m_fetch + 16'd2;
    tests_run++;
    if (q_count !== 3'(mq.size()) || prefetch_idle !== 1'b1) begin
      failed++;
      $display("FAIL read_fill: q_count=%0d idle=%b, required q_count=%0d idle=1", q_count, prefetch_idle, mq.size());
    end
    tests_run++;
    if (q_data !== {mq[1], mq[0]}) begin
      failed++;
      $display("FAIL read_data: q_data=%04h, required %04h", q_data, {mq[1], mq[0]});
    end
    $display("[TB] read addr=%04h data=%04h q_count=%0d", addr, word, q_count);
  endtask

  // Scheduler-driven jump: write the new PC serially and deliver its reply.
  task automatic do_jump(input logic [15:0] npc, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] word;
    write_pc_now = 1'b1;
    tick();
    write_pc_now = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ext_pc_next = 1'b1;
      pc_data_new = npc[2*k +: 2];
      tick();
    end
    ext_pc_next = 1'b0;
    pc_data_new = 2'd0;
    word = {b1, b0};
    for (int k = 0; k < 8; k++) begin
      rx_data_valid = 1'b1;
      rx_pins = word[2*k +: 2];
      rx_done = (k == 7);
      tick();
    end
    rx_data_valid = 1'b0;
    rx_done = 1'b0;
    mq.delete();
    mq.push_back(b0);
    mq.push_back(b1);
    m_pc = npc;
    m_fetch = npc + 16'd2;
    $display("[TB] jump pc=%04h data=%04h", npc, word);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b0 || imm16_loaded !== 1'b0 || prefetch_idle !== 1'b1) begin
      failed++;
      $display("FAIL reset_ctrl: valid=%b imm16_loaded=%b idle=%b, required 0 0 1",
               tx_command_valid, imm16_loaded, prefetch_idle);
    end
    tests_run++;
    if (q_count !== 3'd0 || pc_data !== 2'd0) begin
      failed++;
      $display("FAIL reset_state: q_count=%0d pc_data=%0d, required 0 0", q_count, pc_data);
    end
    reset = 1'b0;
    mq.delete();
    m_pc = 16'h0000;
    m_fetch = 16'h0000;
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b1) begin
      failed++;
      $display("FAIL reset_first_req: valid=%b, required 1", tx_command_valid);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    serve_read(16'h0000, 8'h34, 8'h12);
    tests_run++;
    if (q_data !== 16'h1234 || q_count !== 3'd2) begin
      failed++;
      $display("FAIL first_fetch: q_data=%04h q_count=%0d, required 1234 2", q_data, q_count);
    end
  endtask

  task automatic test_fill();
    int highs;
    serve_read(m_fetch, 8'($urandom), 8'($urandom));
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      if (tx_command_valid !== 1'b0) highs++;
      tick();
    end
    tests_run++;
    if (highs != 0 || q_count !== 3'd4) begin
      failed++;
      $display("FAIL queue_full: valid high %0d cycles q_count=%0d, required 0 cycles 4", highs, q_count);
    end
  endtask

  task automatic test_block();
    consume = 2'd2;
    tick();
    consume = 2'd0;
    void'(mq.pop_front());
    void'(mq.pop_front());
    m_pc = m_pc + 16'd2;
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b1) begin
      failed++;
      $display("FAIL req_after_consume: valid=%b, required 1", tx_command_valid);
    end
    block_prefetch = 1'b1;
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b0 || prefetch_idle !== 1'b1) begin
      failed++;
      $display("FAIL block_drop: valid=%b idle=%b, required 0 1", tx_command_valid, prefetch_idle);
    end
    block_prefetch = 1'b0;
    reserve_tx = 1'b1;
    tick();
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b0) begin
      failed++;
      $display("FAIL reserve_hold: valid=%b, required 0", tx_command_valid);
    end
    reserve_tx = 1'b0;
    tick();
    tests_run++;
    if (tx_command_valid !== 1'b1) begin
      failed++;
      $display("FAIL block_release: valid=%b, required 1", tx_command_valid);
    end
    serve_read(m_fetch, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_imm();
    logic [15:0] m_imm;
    logic [15:0] shifted;
    logic [15:0] pcv;
    do_jump(16'h0010, 8'hEF, 8'hBE);
    tests_run++;
    if (q_data !== 16'hBEEF || q_count !== 3'd2) begin
      failed++;
      $display("FAIL imm_setup: q_data=%04h q_count=%0d, required beef 2", q_data, q_count);
    end
    m_imm = {mq[1], mq[0]};
    void'(mq.pop_front());
    void'(mq.pop_front());
    m_pc = m_pc + 16'd2;
    load_imm16 = 1'b1;
    tick();
    tests_run++;
    if (imm16_loaded !== 1'b1 || q_count !== 3'd0) begin
      failed++;
      $display("FAIL imm_pulse: imm16_loaded=%b q_count=%0d, required 1 0", imm16_loaded, q_count);
    end
    shifted = '0;
    for (int k = 0; k < 8; k++) begin
      load_imm16 = 1'b0;
      next_imm_data = 1'b1;
      shifted[2*k +: 2] = imm_data;
      tick();
      if (k == 0) begin
        tests_run++;
        if (imm16_loaded !== 1'b0) begin
          failed++;
          $display("FAIL imm_pulse_len: imm16_loaded=%b one cycle later, required 0", imm16_loaded);
        end
      end
    end
    next_imm_data = 1'b0;
    tests_run++;
    if (shifted !== m_imm) begin
      failed++;
      $display("FAIL imm_shift: shifted out %04h, required %04h", shifted, m_imm);
    end
    pc_readout(pcv);
    tests_run++;
    if (pcv !== m_pc) begin
      failed++;
      $display("FAIL imm_pc: pc=%04h, required %04h", pcv, m_pc);
    end
    $display("[TB] imm16 value=%04h pc=%04h", shifted, pcv);
  endtask

  task automatic test_pc_read();
    logic [15:0] v1;
    logic [15:0] v2;
    do_jump(16'h8001, 8'($urandom), 8'($urandom));
    pc_readout(v1);
    pc_readout(v2);
    tests_run++;
    if (v1 !== m_pc || v2 !== m_pc) begin
      failed++;
      $display("FAIL pc_read: first=%04h second=%04h, required %04h", v1, v2, m_pc);
    end
  endtask

  task automatic test_jump_wrap();
    do_jump(16'hFFFF, 8'hAA, 8'hBB);
    tests_run++;
    if (q_data !== 16'hBBAA || q_count !== 3'd2) begin
      failed++;
      $display("FAIL jump_queue: q_data=%04h q_count=%0d, required bbaa 2", q_data, q_count);
    end
    serve_read(m_fetch, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_random_traffic();
    int r;
    int lim;
    int c;
    logic [15:0] pcv;
    logic [15:0] m_imm;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(11);
      if (r == 0) begin
        do_jump(16'($urandom), 8'($urandom), 8'($urandom));
        tests_run++;
        if (q_count !== 3'd2 || q_data !== {mq[1], mq[0]}) begin
          failed++;
          $display("FAIL rand_jump: q_data=%04h q_count=%0d, required %04h 2", q_data, q_count, {mq[1], mq[0]});
        end
      end else if (r == 1 && mq.size() >= 2) begin
        m_imm = {mq[1], mq[0]};
        void'(mq.pop_front());
        void'(mq.pop_front());
        m_pc = m_pc + 16'd2;
        load_imm16 = 1'b1;
        tick();
        load_imm16 = 1'b0;
        tests_run++;
        if (imm16_loaded !== 1'b1 || imm_data !== m_imm[1:0] || q_count !== 3'(mq.size())) begin
          failed++;
          $display("FAIL rand_imm: loaded=%b imm_data=%0d q_count=%0d, required 1 %0d %0d",
                   imm16_loaded, imm_data, q_count, m_imm[1:0], mq.size());
        end
        tick();
      end else if (tx_command_valid === 1'b1) begin
        serve_read(m_fetch, 8'($urandom), 8'($urandom));
      end else begin
        lim = (mq.size() >= 2) ? 2 : mq.size();
        c = $urandom_range(lim);
        consume = 2'(c);
        tick();
        consume = 2'd0;
        for (int k = 0; k < c; k++) void'(mq.pop_front());
        m_pc = m_pc + 16'(c);
        tests_run++;
        if (q_count !== 3'(mq.size())) begin
          failed++;
          $display("FAIL rand_consume: q_count=%0d, required %0d", q_count, mq.size());
        end
      end
    end
    pc_readout(pcv);
    tests_run++;
    if (pcv !== m_pc) begin
      failed++;
      $display("FAIL rand_pc: pc=%04h, required %04h", pcv, m_pc);
    end
  endtask

  task automatic test_reset_mid_reply();
    int waited;
    logic [15:0] word;
    do_reset();
    waited = 0;
    while (tx_command_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    tests_run++;
    if (tx_command_valid !== 1'b1) begin
      failed++;
      $display("FAIL midrst_wait: valid=%b, required 1", tx_command_valid);
    end
    tx_command_started = 1'b1;
    tick();
    tx_command_started = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tx_data_next = 1'b1;
      tick();
    end
    tx_data_next = 1'b0;
    word = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      rx_data_valid = 1'b1;
      rx_pins = word[2*k +: 2];
      tick();
    end
    rx_data_valid = 1'b0;
    reset = 1'b1;
    tick();
    tests_run++;
    if (q_count !== 3'd0 || prefetch_idle !== 1'b1 || tx_command_valid !== 1'b0) begin
      failed++;
      $display("FAIL midrst_state: q_count=%0d idle=%b valid=%b, required 0 1 0",
               q_count, prefetch_idle, tx_command_valid);
    end
    reset = 1'b0;
    mq.delete();
    m_pc = 16'h0000;
    m_fetch = 16'h0000;
    serve_read(16'h0000, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_fill();
    test_block();
    test_imm();
    test_pc_read();
    test_jump_wrap();
    test_random_traffic();
    test_reset_mid_reply();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
